// File: rtl/bus_slave_if_pkg.sv
// Shared bus definitions: active-low enable levels, transfer direction,
// word widths and the slave adapter state encodings.
package bus_slave_if_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef enum logic [1:0] {
        BUS_SLV_STATE_IDLE = 2'h0,
        BUS_SLV_STATE_REQ  = 2'h1,
        BUS_SLV_STATE_RESP = 2'h2
    } bus_slv_state_e;

endpackage

// File: rtl/bus_slave_if.sv
// Slave end of the shared bus: captures a strobe for this slot, forwards it
// to the local device over req/ack and returns one ready cycle, with timeout.
//
// state | meaning
// IDLE  | waiting for a strobe addressed to this slot
// REQ   | dev_req held high, waiting for dev_ack or timeout
// RESP  | single cycle with bus_rdy_ low and read data driven
module bus_slave_if
    import bus_slave_if_pkg::*;
#(
    parameter int          ADDR_W   = WORD_ADDR_W,
    parameter int          DATA_W   = WORD_DATA_W,
    parameter int          TO_W     = 8,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_cs_,
    input  logic              bus_as_,
    input  logic              bus_rw,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wr_data,
    output logic              bus_rdy_,
    output logic [DATA_W-1:0] bus_rd_data,
    output logic              dev_req,
    output logic              dev_rw,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wr_data,
    input  logic              dev_ack,
    input  logic [DATA_W-1:0] dev_rd_data,
    output logic              err_timeout,
    output logic              err_proto
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    bus_slv_state_e  state;
    logic [TO_W-1:0] count;
    logic            strobe;

    assign strobe = (bus_as_ == ENABLE_) && (bus_cs_ == ENABLE_);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BUS_SLV_STATE_IDLE;
            bus_rdy_    <= DISABLE_;
            bus_rd_data <= '0;
            dev_req     <= 1'b0;
            dev_rw      <= READ;
            dev_addr    <= '0;
            dev_wr_data <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            count       <= '0;
        end else begin
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            case (state)
                BUS_SLV_STATE_IDLE: begin
                    if (strobe) begin
                        dev_rw      <= bus_rw;
                        dev_addr    <= bus_addr;
                        dev_wr_data <= bus_wr_data;
                        dev_req     <= 1'b1;
                        count       <= '0;
                        state       <= BUS_SLV_STATE_REQ;
                    end
                end
                BUS_SLV_STATE_REQ: begin
                    err_proto <= strobe;
                    // Ack is checked first so a late ack still returns real data.
                    if (dev_ack) begin
                        dev_req     <= 1'b0;
                        bus_rd_data <= (dev_rw == READ) ? dev_rd_data : '0;
                        bus_rdy_    <= ENABLE_;
                        state       <= BUS_SLV_STATE_RESP;
                    end else if (TIMEOUT != 0 && count == TO_LAST) begin
                        dev_req     <= 1'b0;
                        bus_rd_data <= (dev_rw == READ) ? DATA_W'(ERR_DATA) : '0;
                        bus_rdy_    <= ENABLE_;
                        err_timeout <= 1'b1;
                        state       <= BUS_SLV_STATE_RESP;
                    end else if (count != '1) begin
                        count <= count + 1'b1;
                    end
                end
                BUS_SLV_STATE_RESP: begin
                    err_proto   <= strobe;
                    bus_rdy_    <= DISABLE_;
                    bus_rd_data <= '0;
                    dev_rw      <= READ;
                    dev_addr    <= '0;
                    dev_wr_data <= '0;
                    state       <= BUS_SLV_STATE_IDLE;
                end
                default: begin
                    state    <= BUS_SLV_STATE_IDLE;
                    bus_rdy_ <= DISABLE_;
                    dev_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_slave_if.md
Name: bus_slave_if

Overview:
- Responder-side adapter for the shared on-chip bus: the slave end of the req/grant/as_/rdy_ protocol driven by the CPU bus master interfaces.
- Decodes a strobe addressed to its slot, holds the transfer, and hands it to a local device over a simple req/ack handshake.
- Returns bus_rdy_ and read data, with a timeout so a dead device cannot hang the bus.
- Instantiated once per bus slave (ROM, UART, GPIO, timer) between the bus decoder/mux and the peripheral core.

Parameters:
ADDR_W, 30, word-address width (matches bus_addr)
DATA_W, 32, data width
TO_W, 8, timeout counter width
TIMEOUT, 16, cycles in REQ without dev_ack before forced error response; 0 disables timeout; must be < 2**TO_W
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
bus_cs_  in  1  slot select from bus address decoder, active-low
bus_as_  in  1  address strobe, active-low, one cycle per transfer
bus_rw  in  1  0=READ, 1=WRITE
bus_addr  in  ADDR_W  word address
bus_wr_data  in  DATA_W  write data
bus_rdy_  out  1  ready, active-low, registered
bus_rd_data  out  DATA_W  read data, registered, 0 when not ready
dev_req  out  1  request to local device, level, registered
dev_rw  out  1  latched bus_rw
dev_addr  out  ADDR_W  latched bus_addr
dev_wr_data  out  DATA_W  latched bus_wr_data
dev_ack  in  1  device done, sampled while dev_req=1
dev_rd_data  in  DATA_W  device read data, valid with dev_ack
err_timeout  out  1  one-cycle pulse on timeout
err_proto  out  1  one-cycle pulse on strobe received while busy

Behaviour:
- Reset values: state=IDLE; bus_rdy_=1; bus_rd_data=0; dev_req=0; dev_rw=READ; dev_addr=0; dev_wr_data=0; err_*=0; timeout count=0. Reset mid-transfer aborts without a response; dev_req drops on the next edge.
- States: IDLE, REQ, RESP (2-bit encoding).
- IDLE: on bus_as_=0 and bus_cs_=0, latch rw/addr/wr_data into dev_*, set dev_req<=1, clear count, go to REQ. A strobe with bus_cs_=1 is ignored.
- REQ: dev_req is held high and dev_* are held stable.
  - If dev_ack=1: dev_req<=0; bus_rd_data<=dev_rd_data for a read, 0 for a write; bus_rdy_<=0; go to RESP.
  - Else, if TIMEOUT!=0 and count==TIMEOUT-1: dev_req<=0; bus_rd_data<=ERR_DATA for a read, 0 for a write; bus_rdy_<=0; err_timeout<=1 for one cycle; go to RESP.
  - Else count<=count+1. The counter saturates and never wraps.
  - dev_ack and timeout in the same cycle: ack wins, no error.
- RESP: exactly one cycle with bus_rdy_=0. Next edge: bus_rdy_<=1, bus_rd_data<=0, dev_* cleared to reset values, go to IDLE.
- Latency: strobe in cycle N gives dev_req=1 in N+1. With dev_ack in cycle N+1+k, bus_rdy_=0 in N+2+k. The minimum is 2 cycles.
- The master holds bus_addr, bus_rw and bus_req_ until it sees rdy_; the slave does not re-sample them after cycle N.
- bus_as_=0 with bus_cs_=0 in REQ or RESP: ignored, err_proto pulses one cycle, the transfer in progress is unaffected.
- dev_ack while dev_req=0 is ignored.
- The outputs drive a wired-OR/mux bus, so bus_rd_data must be 0 and bus_rdy_ must be 1 whenever the state is not RESP.

Decomposition:
- Shared bus header holds: ENABLE_/DISABLE_, READ/WRITE, WORD_ADDR_W/WORD_DATA_W, and new BUS_SLV_STATE_IDLE/REQ/RESP encodings.
- The timeout counter is small enough to stay inline; no sub-module.

Test Plan:
- Read, ack same cycle as dev_req: strobe cycle 0 with addr=30'h100, dev_rd_data=32'h1234_5678 -> dev_req high in cycle 1; bus_rdy_=0 and bus_rd_data=32'h1234_5678 in cycle 2; idle in cycle 3.
- Write, ack delayed 3 cycles: wr_data=32'hA5A5_0001 -> dev_wr_data stable cycles 1-4; bus_rdy_=0 in cycle 5 with bus_rd_data=0.
- Timeout, no ack, TIMEOUT=16, read -> err_timeout pulse and bus_rdy_=0 with bus_rd_data=32'hDEAD_BEEF in cycle 17; dev_req low from cycle 17.
- Strobe with bus_cs_=1 -> no dev_req and bus_rdy_ stays 1. A second strobe with cs_=0 during REQ -> err_proto pulse, and the original transfer completes unchanged.
- Reset asserted in REQ -> next cycle: state IDLE, dev_req=0, bus_rdy_=1, no response. The next strobe is served normally.
- Ack and timeout in the same cycle (ack at cycle 16) -> normal data returned, err_timeout stays 0.
